// File: rtl/kmeans_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kmeans_pkg
// Brief    : Shared sizes, reset centroids and FSM encoding for the k-means
//            centroid update stage.
// Revision : 1.0 - initial release
// ============================================================================
package kmeans_pkg;

  localparam int K       = 5;
  localparam int COORD_W = 14;
  localparam int SUM_W   = 24;
  localparam int CNT_W   = 14;
  localparam int Q_W     = $clog2(2 * K);
  localparam int BIT_W   = $clog2(SUM_W);

  // Cluster 0 sits in the LSBs.
  localparam logic [K*COORD_W-1:0] RST_CEN_X = {COORD_W'(5000), COORD_W'(10000),
                                               COORD_W'(10000), COORD_W'(0), COORD_W'(0)};
  localparam logic [K*COORD_W-1:0] RST_CEN_Y = {COORD_W'(5000), COORD_W'(10000),
                                               COORD_W'(0), COORD_W'(10000), COORD_W'(0)};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_DIV   = 3'd2,
    S_WB    = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/centroid_update_if.sv
`default_nettype none
// ============================================================================
// Module   : centroid_update_if
// Brief    : Sums/counts in, centroids and status out, for centroid_update.
// Revision : 1.0 - initial release
// ============================================================================
interface centroid_update_if;
  import kmeans_pkg::*;

  logic                 start;
  logic [K*SUM_W-1:0]   sum_x;
  logic [K*SUM_W-1:0]   sum_y;
  logic [K*CNT_W-1:0]   count;
  logic                 init_load;
  logic [K*COORD_W-1:0] init_x;
  logic [K*COORD_W-1:0] init_y;
  logic [K*COORD_W-1:0] cen_x;
  logic [K*COORD_W-1:0] cen_y;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [K-1:0]         empty_mask;
  logic [7:0]           iter_count;

  modport master (
    output start, sum_x, sum_y, count, init_load, init_x, init_y,
    input  cen_x, cen_y, busy, done, converged, empty_mask, iter_count
  );

  modport slave (
    input  start, sum_x, sum_y, count, init_load, init_x, init_y,
    output cen_x, cen_y, busy, done, converged, empty_mask, iter_count
  );

endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : SUM_W-bit unsigned restoring divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
  import kmeans_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [SUM_W-1:0] dividend,
  input  wire logic [SUM_W-1:0] divisor,
  output logic      [SUM_W-1:0] quotient,
  output logic                  div_by_zero
);

  localparam int             CW    = $clog2(SUM_W + 1);
  localparam logic [CW-1:0]  STEPS = CW'(SUM_W);

  logic [SUM_W-1:0] r_quo;
  logic [SUM_W-1:0] r_rem;
  logic [SUM_W-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [SUM_W:0]   w_shift;
  logic [SUM_W:0]   w_diff;

  // Dividend bits shift out of r_quo's MSB as quotient bits shift into its LSB.
  assign w_shift = {r_rem, r_quo[SUM_W-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
      r_cnt <= STEPS;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      if (!w_diff[SUM_W]) begin
        r_rem <= w_diff[SUM_W-1:0];
        r_quo <= {r_quo[SUM_W-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[SUM_W-1:0];
        r_quo <= {r_quo[SUM_W-2:0], 1'b0};
      end
    end
  end

  assign quotient    = r_quo;
  assign div_by_zero = (r_dvs == '0);

endmodule
`default_nettype wire

// File: rtl/centroid_update.sv
`default_nettype none
// ============================================================================
// Module   : centroid_update
// Brief    : Recomputes K centroids as sum/count with one shared divider and
//            reports convergence and empty clusters.
// Revision : 1.0 - initial release
// ============================================================================
module centroid_update
  import kmeans_pkg::*;
#(
  parameter int THRESH = 0
)
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  centroid_update_if.slave bus
);

  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(SUM_W - 1);
  localparam logic [Q_W-1:0]     Q_LAST   = Q_W'(2 * K - 1);
  localparam logic [COORD_W:0]   THRESH_V = (COORD_W + 1)'(THRESH);

  state_t             r_state;
  state_t             w_next;
  logic [SUM_W-1:0]   r_sum_x [K];
  logic [SUM_W-1:0]   r_sum_y [K];
  logic [CNT_W-1:0]   r_cnt   [K];
  logic [COORD_W-1:0] r_cen_x [K];
  logic [COORD_W-1:0] r_cen_y [K];
  logic [COORD_W-1:0] r_old_x [K];
  logic [COORD_W-1:0] r_old_y [K];
  logic [Q_W-1:0]     r_q;
  logic [BIT_W-1:0]   r_bit;
  logic [K-1:0]       r_empty_work;
  logic [K-1:0]       r_empty;
  logic               r_conv;
  logic [7:0]         r_iter;

  logic [Q_W-2:0]     w_k;
  logic               w_is_y;
  logic               w_load;
  logic [SUM_W-1:0]   w_dividend;
  logic [SUM_W-1:0]   w_divisor;
  logic [SUM_W-1:0]   w_quo;
  logic               w_dbz;
  logic [COORD_W-1:0] w_wr_val;
  logic [COORD_W:0]   w_shift [K];
  logic               w_conv;

  assign w_k        = r_q[Q_W-1:1];
  assign w_is_y     = r_q[0];
  assign w_dividend = w_is_y ? r_sum_y[w_k] : r_sum_x[w_k];
  assign w_divisor  = {{(SUM_W-CNT_W){1'b0}}, r_cnt[w_k]};
  assign w_wr_val   = (|w_quo[SUM_W-1:COORD_W]) ? '1 : w_quo[COORD_W-1:0];

  seq_divider u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (w_load),
    .dividend    (w_dividend),
    .divisor     (w_divisor),
    .quotient    (w_quo),
    .div_by_zero (w_dbz)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      S_IDLE:  if (!bus.init_load && bus.start) w_next = S_SETUP;
      S_SETUP: begin
        w_load = 1'b1;
        w_next = S_DIV;
      end
      S_DIV:   if (r_bit == BIT_LAST) w_next = S_WB;
      S_WB:    w_next = (r_q == Q_LAST) ? S_CHECK : S_SETUP;
      S_CHECK: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Empty clusters keep their centroid, so they contribute zero shift here.
  always_comb begin
    w_conv = 1'b1;
    for (int i = 0; i < K; i++) begin
      w_shift[i] = abs_diff(r_cen_x[i], r_old_x[i]) + abs_diff(r_cen_y[i], r_old_y[i]);
      if (w_shift[i] > THRESH_V) w_conv = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        r_cen_x[i] <= RST_CEN_X[i*COORD_W +: COORD_W];
        r_cen_y[i] <= RST_CEN_Y[i*COORD_W +: COORD_W];
        r_old_x[i] <= '0;
        r_old_y[i] <= '0;
        r_sum_x[i] <= '0;
        r_sum_y[i] <= '0;
        r_cnt[i]   <= '0;
      end
      r_q          <= '0;
      r_bit        <= '0;
      r_empty_work <= '0;
      r_empty      <= '0;
      r_conv       <= 1'b0;
      r_iter       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.init_load) begin
            for (int i = 0; i < K; i++) begin
              r_cen_x[i] <= bus.init_x[i*COORD_W +: COORD_W];
              r_cen_y[i] <= bus.init_y[i*COORD_W +: COORD_W];
            end
            r_iter <= '0;
          end else if (bus.start) begin
            for (int i = 0; i < K; i++) begin
              r_sum_x[i] <= bus.sum_x[i*SUM_W +: SUM_W];
              r_sum_y[i] <= bus.sum_y[i*SUM_W +: SUM_W];
              r_cnt[i]   <= bus.count[i*CNT_W +: CNT_W];
              r_old_x[i] <= r_cen_x[i];
              r_old_y[i] <= r_cen_y[i];
            end
            r_q          <= '0;
            r_empty_work <= '0;
          end
        end
        S_SETUP: r_bit <= '0;
        S_DIV:   r_bit <= r_bit + 1'b1;
        S_WB: begin
          if (w_dbz)       r_empty_work[w_k] <= 1'b1;
          else if (w_is_y) r_cen_y[w_k]      <= w_wr_val;
          else             r_cen_x[w_k]      <= w_wr_val;
          r_q <= r_q + 1'b1;
        end
        S_CHECK: begin
          r_conv  <= w_conv;
          r_empty <= r_empty_work;
          if (r_iter != 8'hFF) r_iter <= r_iter + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_pack
    assign bus.cen_x[i*COORD_W +: COORD_W] = r_cen_x[i];
    assign bus.cen_y[i*COORD_W +: COORD_W] = r_cen_y[i];
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = (r_state == S_DONE);
  assign bus.converged  = r_conv;
  assign bus.empty_mask = r_empty;
  assign bus.iter_count = r_iter;

endmodule
`default_nettype wire
